// File: rtl/handshake_window_monitor.sv
// Multi-channel req/ack protocol checker: measures ack latency after each req rise
// and reports EARLY / LATE / ACK_NO_REQ / PROTO violations as pulses, sticky bits and a count.
module handshake_window_monitor #(
    parameter int NUM_CH        = 2,
    parameter int MIN_ACK_CYCLE = 2,
    parameter int MAX_ACK_CYCLE = 4,
    parameter bit REQ_HOLD      = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [NUM_CH-1:0]     req,
    input  logic [NUM_CH-1:0]     ack,
    output logic [4*NUM_CH-1:0]   fire,
    output logic [4*NUM_CH-1:0]   err_sticky,
    output logic [CNT_W-1:0]      err_count,
    output logic [NUM_CH-1:0]     busy
);

    localparam int CW = $clog2(MAX_ACK_CYCLE + 1);
    localparam int PW = $clog2(4 * NUM_CH + 1);
    localparam int SW = CNT_W + PW;

    localparam logic [CW-1:0] MIN_C = CW'(MIN_ACK_CYCLE);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_ACK_CYCLE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_STALE = 2'd2;

    localparam int F_EARLY = 0;
    localparam int F_LATE  = 1;
    localparam int F_ANR   = 2;
    localparam int F_PROTO = 3;

    generate
        if (MIN_ACK_CYCLE < 1 || MAX_ACK_CYCLE < MIN_ACK_CYCLE) begin : g_param_check
            $error("handshake_window_monitor: need 1 <= MIN_ACK_CYCLE <= MAX_ACK_CYCLE");
        end
    endgenerate

    logic [1:0]          state      [NUM_CH];
    logic [1:0]          state_next [NUM_CH];
    logic [CW-1:0]       cnt        [NUM_CH];
    logic [CW-1:0]       cnt_next   [NUM_CH];
    logic [NUM_CH-1:0]   req_q;
    logic                armed;
    logic [NUM_CH-1:0]   rise;
    logic [4*NUM_CH-1:0] fire_next;
    logic [PW-1:0]       fire_pop;
    logic [SW-1:0]       count_sum;
    logic [CNT_W-1:0]    count_next;

    // armed stays low until the first enabled edge so a req already high at reset release is ignored
    assign rise = req & ~req_q & {NUM_CH{armed}};

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
            state_next[c]       = state[c];
            cnt_next[c]         = cnt[c];
            fire_next[4*c +: 4] = 4'b0000;
            if (!enable) begin
                state_next[c] = S_IDLE;
                cnt_next[c]   = '0;
            end else begin
                case (state[c])
                    S_IDLE: begin
                        if (ack[c]) begin
                            fire_next[4*c + F_ANR] = 1'b1;
                        end else if (rise[c]) begin
                            state_next[c] = S_WAIT;
                            cnt_next[c]   = CW'(1);
                        end
                    end
                    S_WAIT: begin
                        if (ack[c]) begin
                            if (cnt[c] < MIN_C) fire_next[4*c + F_EARLY] = 1'b1;
                            state_next[c] = S_IDLE;
                            cnt_next[c]   = '0;
                        end else if (REQ_HOLD && !req[c]) begin
                            fire_next[4*c + F_PROTO] = 1'b1;
                            state_next[c] = S_IDLE;
                            cnt_next[c]   = '0;
                        end else if (rise[c]) begin
                            fire_next[4*c + F_PROTO] = 1'b1;
                            cnt_next[c]   = CW'(1);
                        end else if (cnt[c] == MAX_C) begin
                            fire_next[4*c + F_LATE] = 1'b1;
                            state_next[c] = S_STALE;
                            cnt_next[c]   = '0;
                        end else begin
                            cnt_next[c]   = cnt[c] + CW'(1);
                        end
                    end
                    S_STALE: begin
                        if (!req[c] && !ack[c]) state_next[c] = S_IDLE;
                    end
                    default: begin
                        state_next[c] = S_IDLE;
                        cnt_next[c]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        fire_pop = '0;
        for (int i = 0; i < 4 * NUM_CH; i++) begin
            fire_pop = fire_pop + PW'(fire_next[i]);
        end
        count_sum  = SW'(err_count) + SW'(fire_pop);
        // any carry above CNT_W bits means the counter would wrap, so pin it at all-ones
        count_next = (|count_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            busy[c] = (state[c] == S_WAIT);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state[c] <= S_IDLE;
                cnt[c]   <= '0;
            end
            req_q      <= '0;
            armed      <= 1'b0;
            fire       <= '0;
            err_sticky <= '0;
            err_count  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state[c] <= state_next[c];
                cnt[c]   <= cnt_next[c];
            end
            req_q      <= req;
            armed      <= armed | enable;
            fire       <= fire_next;
            err_sticky <= clear ? '0 : (err_sticky | fire_next);
            err_count  <= clear ? '0 : count_next;
        end
    end

endmodule

// File: tb/tb_handshake_window_monitor.sv
// Bench for handshake_window_monitor: directed scenarios plus random traffic, checked by a
// scoreboard fed from a timestamp-based reference model of the req/ack latency rules.
module tb_handshake_window_monitor;

    localparam int NCH   = 2;
    localparam int MIN_L = 2;
    localparam int MAX_L = 4;
    localparam bit HOLD  = 1'b1;
    localparam int CW    = 8;
    localparam int FW    = 4 * NCH;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable  = 1'b0;
    logic            clear   = 1'b0;
    logic [NCH-1:0]  req     = '0;
    logic [NCH-1:0]  ack     = '0;
    logic [FW-1:0]   fire;
    logic [FW-1:0]   err_sticky;
    logic [CW-1:0]   err_count;
    logic [NCH-1:0]  busy;

    handshake_window_monitor #(
        .NUM_CH(NCH), .MIN_ACK_CYCLE(MIN_L), .MAX_ACK_CYCLE(MAX_L),
        .REQ_HOLD(HOLD), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .req(req), .ack(ack), .fire(fire), .err_sticky(err_sticky),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0]  fire;
        logic [FW-1:0]  sticky;
        logic [CW-1:0]  count;
        logic [NCH-1:0] busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: a pending request remembers the edge index at which it started
    int unsigned   m_cyc;
    bit            m_pend  [NCH];
    bit            m_stale [NCH];
    bit            m_prev  [NCH];
    int unsigned   m_start [NCH];
    bit            m_armed;
    logic [FW-1:0] m_sticky;
    int            m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc    = 0;
        m_armed  = 1'b0;
        m_sticky = '0;
        m_count  = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_pend[ch]  = 1'b0;
            m_stale[ch] = 1'b0;
            m_prev[ch]  = 1'b0;
            m_start[ch] = 0;
        end
    endtask

    task automatic model_edge(input logic [NCH-1:0] r, input logic [NCH-1:0] a,
                              input logic e, input logic c, output exp_t x);
        logic [FW-1:0] f;
        bit            rise;
        int unsigned   lat;
        f = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            rise = m_armed && r[ch] && !m_prev[ch];
            if (!e) begin
                m_pend[ch]  = 1'b0;
                m_stale[ch] = 1'b0;
            end else if (m_stale[ch]) begin
                if (!r[ch] && !a[ch]) m_stale[ch] = 1'b0;
            end else if (m_pend[ch]) begin
                lat = m_cyc - m_start[ch];
                if (a[ch]) begin
                    if (lat < MIN_L) f[4*ch] = 1'b1;
                    m_pend[ch] = 1'b0;
                end else if (HOLD && !r[ch]) begin
                    f[4*ch+3]  = 1'b1;
                    m_pend[ch] = 1'b0;
                end else if (rise) begin
                    f[4*ch+3]   = 1'b1;
                    m_start[ch] = m_cyc;
                end else if (lat == MAX_L) begin
                    f[4*ch+1]   = 1'b1;
                    m_pend[ch]  = 1'b0;
                    m_stale[ch] = 1'b1;
                end
            end else begin
                if (a[ch]) begin
                    f[4*ch+2] = 1'b1;
                end else if (rise) begin
                    m_pend[ch]  = 1'b1;
                    m_start[ch] = m_cyc;
                end
            end
            m_prev[ch] = r[ch];
        end
        m_armed = m_armed || e;
        if (c) begin
            m_sticky = '0;
            m_count  = 0;
        end else begin
            m_sticky = m_sticky | f;
            m_count  = m_count + $countones(f);
            if (m_count > (1 << CW) - 1) m_count = (1 << CW) - 1;
        end
        m_cyc++;
        x.fire   = f;
        x.sticky = m_sticky;
        x.count  = CW'(m_count);
        for (int ch = 0; ch < NCH; ch++) x.busy[ch] = m_pend[ch];
    endtask

    // drive inputs for the coming edge and queue the model's view of the outputs after it
    task automatic apply(input logic [NCH-1:0] r, input logic [NCH-1:0] a,
                         input logic e, input logic c);
        exp_t x;
        req    = r;
        ack    = a;
        enable = e;
        clear  = c;
        model_edge(r, a, e, c, x);
        sb_q.push_back(x);
    endtask

    task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] a,
                        input logic e, input logic c);
        @(negedge clk);
        #1;
        apply(r, a, e, c);
    endtask

    task automatic go(input logic [NCH-1:0] r, input logic [NCH-1:0] a);
        step(r, a, 1'b1, 1'b0);
    endtask

    // move from just after a negedge to just after the following posedge
    task automatic settle();
        #5;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fire"},   32'(fire),       32'(0));
        check({tag, "_sticky"}, 32'(err_sticky), 32'(0));
        check({tag, "_count"},  32'(err_count),  32'(0));
        check({tag, "_busy"},   32'(busy),       32'(0));
    endtask

    task automatic reset_pulse(input logic [NCH-1:0] r_hold);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        req     = r_hold;
        ack     = '0;
        clear   = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        apply(r_hold, '0, 1'b1, 1'b0);
    endtask

    // monitor: compares every queued expectation against the DUT half a cycle after its edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_fire",   32'(fire),       32'(e.fire));
                check("sb_sticky", 32'(err_sticky), 32'(e.sticky));
                check("sb_count",  32'(err_count),  32'(e.count));
                check("sb_busy",   32'(busy),       32'(e.busy));
            end
        end
    end

    initial begin
        logic [NCH-1:0] r;
        logic [NCH-1:0] a;
        logic           en;
        logic           cl;

        model_reset();
        #1;
        check_zero("reset_state");
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        apply('0, '0, 1'b1, 1'b0);

        // legal latencies 2 and 4 on ch0
        go(2'b01, 2'b00);
        settle();
        check("t1_busy_wait", 32'(busy), 32'h1);
        go(2'b01, 2'b00);
        go(2'b01, 2'b01);
        settle();
        check("t1_l2_fire", 32'(fire), 32'h0);
        check("t1_l2_busy", 32'(busy), 32'h0);
        go(2'b00, 2'b00);
        repeat (4) go(2'b01, 2'b00);
        go(2'b01, 2'b01);
        settle();
        check("t1_l4_fire",  32'(fire),      32'h0);
        check("t1_l4_count", 32'(err_count), 32'h0);
        go(2'b00, 2'b00);

        // early ack at L=1, then missing ack reported LATE at L=4, late ack ignored
        go(2'b01, 2'b00);
        go(2'b01, 2'b01);
        settle();
        check("t2_early", 32'(fire), 32'h01);
        go(2'b00, 2'b00);
        settle();
        check("t2_early_once", 32'(fire), 32'h00);
        repeat (5) go(2'b01, 2'b00);
        settle();
        check("t2_late", 32'(fire), 32'h02);
        go(2'b01, 2'b01);
        settle();
        check("t2_stale_ack", 32'(fire), 32'h00);
        go(2'b00, 2'b00);
        settle();
        check("t2_count", 32'(err_count), 32'h2);

        // ch1: ack without request, then req dropped before ack
        step(2'b00, 2'b00, 1'b1, 1'b1);
        go(2'b00, 2'b10);
        settle();
        check("t3_ack_no_req", 32'(fire), 32'h40);
        go(2'b10, 2'b00);
        go(2'b10, 2'b00);
        go(2'b00, 2'b00);
        settle();
        check("t3_proto",  32'(fire),       32'h80);
        check("t3_sticky", 32'(err_sticky), 32'hC0);

        // ch0 EARLY and ch1 LATE on the same edge
        go(2'b10, 2'b00);
        go(2'b10, 2'b00);
        go(2'b10, 2'b00);
        go(2'b11, 2'b00);
        go(2'b11, 2'b01);
        settle();
        check("t4_dual_fire",  32'(fire),      32'h21);
        check("t4_dual_count", 32'(err_count), 32'h4);
        go(2'b00, 2'b00);
        step(2'b00, 2'b00, 1'b1, 1'b1);
        settle();
        check("t4_clr_sticky", 32'(err_sticky), 32'h0);
        check("t4_clr_count",  32'(err_count),  32'h0);

        // counter saturation
        repeat (127) go(2'b00, 2'b11);
        settle();
        check("t5_count_254", 32'(err_count), 32'hFE);
        go(2'b00, 2'b01);
        settle();
        check("t5_count_255", 32'(err_count), 32'hFF);
        go(2'b00, 2'b01);
        settle();
        check("t5_count_sat", 32'(err_count), 32'hFF);
        go(2'b00, 2'b00);

        // async reset in the middle of a wait, req held high through release
        go(2'b01, 2'b00);
        go(2'b01, 2'b00);
        settle();
        check("t6_busy_pre", 32'(busy), 32'h1);
        reset_pulse(2'b01);
        repeat (3) go(2'b01, 2'b00);
        settle();
        check("t6_no_req_after_rst", 32'(busy), 32'h0);
        go(2'b00, 2'b00);

        // disabled: nothing fires, and a req high at enable rise starts nothing
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b01, 1'b0, 1'b0);
        step(2'b00, 2'b11, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        settle();
        check("t7_dis_fire", 32'(fire), 32'h0);
        check("t7_dis_busy", 32'(busy), 32'h0);
        repeat (3) go(2'b01, 2'b00);
        settle();
        check("t7_en_busy", 32'(busy), 32'h0);
        check("t7_en_fire", 32'(fire), 32'h0);
        go(2'b00, 2'b00);
        go(2'b01, 2'b00);
        settle();
        check("t7_new_req", 32'(busy), 32'h1);
        go(2'b01, 2'b00);
        go(2'b01, 2'b01);
        go(2'b00, 2'b00);

        // random traffic
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 5) == 0) r[ch] = ~r[ch];
                a[ch] = ($urandom_range(0, 4) == 0);
            end
            en = ($urandom_range(0, 19) != 0);
            cl = ($urandom_range(0, 49) == 0);
            step(r, a, en, cl);
        end
        go(2'b00, 2'b00);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
